// File: rtl/fb_pixel_writer.sv
// Pixel plotter for a 1-bpp framebuffer. SET/XOR commands are read-modify-write
// cycles against a shadow RAM; FILL streams a constant word over the whole buffer.
module fb_pixel_writer #(
  parameter int unsigned H_PIXELS = 640,
  parameter int unsigned V_PIXELS = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [9:0]  cmd_x,
  input  logic [8:0]  cmd_y,
  input  logic        cmd_color,
  output logic [14:0] mem_rdaddr,
  input  logic [31:0] mem_rddata,
  output logic [14:0] mem_wraddr,
  output logic [31:0] mem_wdata,
  output logic        mem_wren,
  output logic        busy,
  output logic        done,
  output logic [7:0]  err_count
);

  localparam int unsigned WORDS_PER_LINE = H_PIXELS / 32;
  localparam int unsigned FB_WORDS       = WORDS_PER_LINE * V_PIXELS;
  localparam logic [14:0] LAST_WORD      = 15'(FB_WORDS - 1);

  localparam logic [1:0] OP_SET  = 2'b00;
  localparam logic [1:0] OP_FILL = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {IDLE, RD_WAIT, MODIFY, FILL} state_t;

  state_t      state;
  logic [14:0] word;
  logic [14:0] pix_word;
  logic [4:0]  pix_bit;
  logic        pix_xor;
  logic        pix_color;
  logic        coord_bad;
  logic        cmd_bad;
  logic [31:0] merged;

  assign cmd_ready = (state == IDLE) && reset;
  assign busy      = (state != IDLE);

  assign word      = 15'(cmd_y) * 15'(WORDS_PER_LINE) + 15'(cmd_x[9:5]);
  assign coord_bad = (32'(cmd_x) >= H_PIXELS) || (32'(cmd_y) >= V_PIXELS);
  // FILL ignores its coordinates, so they cannot make it invalid
  assign cmd_bad   = (cmd_op == OP_RSVD) || ((cmd_op != OP_FILL) && coord_bad);

  always_comb begin
    merged          = mem_rddata;
    merged[pix_bit] = pix_xor ? ~mem_rddata[pix_bit] : pix_color;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      mem_rdaddr <= '0;
      mem_wraddr <= '0;
      mem_wdata  <= '0;
      mem_wren   <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      pix_word   <= '0;
      pix_bit    <= '0;
      pix_xor    <= 1'b0;
      pix_color  <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_bad) begin
              done <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else if (cmd_op == OP_FILL) begin
              state      <= FILL;
              mem_wraddr <= '0;
              mem_wdata  <= {32{cmd_color}};
              mem_wren   <= 1'b1;
            end else begin
              state      <= RD_WAIT;
              mem_rdaddr <= word;
              pix_word   <= word;
              pix_bit    <= cmd_x[4:0];
              pix_xor    <= (cmd_op != OP_SET);
              pix_color  <= cmd_color;
            end
          end
        end
        RD_WAIT: state <= MODIFY;
        MODIFY: begin
          state      <= IDLE;
          mem_wraddr <= pix_word;
          mem_wdata  <= merged;
          mem_wren   <= 1'b1;
          done       <= 1'b1;
        end
        FILL: begin
          // mem_wraddr doubles as the fill word counter
          if (mem_wraddr == LAST_WORD) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            mem_wraddr <= mem_wraddr + 15'd1;
            mem_wren   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
